frame_pair_streamer: RTL and testbench
======================================

// Module: frame_pair_streamer
// PURPOSE
// Raster-order source for the optical-flow gradient stage. Reads the current and previous frames
// from a two-bank frame store (ping-pong, shared address). Drives the pixel_curr/pixel_prev/
// pixel_valid stream that the gradient stage consumes, one pixel pair per beat.
// Runs one frame per start pulse, with optional horizontal blanking between lines.
// PARAMETERS
// PIXEL_WIDTH  8    bits per pixel
// IMG_WIDTH    320  pixels per line
// IMG_HEIGHT   240  lines per frame
// H_BLANK      0    idle cycles inserted after every line except the last (0 = back-to-back)
// RD_LATENCY   1    frame-store read latency in cycles (>=1), rdata valid RD_LATENCY after rd_en
// ADDR_WIDTH   $clog2(IMG_WIDTH*IMG_HEIGHT)  frame-store address width
// PORTS
// clk          in   1            single clock
// rst_n        in   1            asynchronous, active-low reset
// start        in   1            pulse; begins one frame when idle
// curr_bank    in   1            bank holding the current frame; sampled on accepted start
// mem_rd_en    out  1            frame-store read strobe (both banks)
// mem_addr     out  ADDR_WIDTH   read address, y*IMG_WIDTH+x (both banks)
// mem_rdata_0  in   PIXEL_WIDTH  bank 0 read data
// mem_rdata_1  in   PIXEL_WIDTH  bank 1 read data
// pixel_curr   out  PIXEL_WIDTH  current-frame pixel
// pixel_prev   out  PIXEL_WIDTH  previous-frame pixel
// pixel_valid  out  1            pixel pair valid this cycle
// busy         out  1            state != IDLE
// done         out  1            one-cycle pulse after last valid beat
// BEHAVIOUR
// - Reset: every output 0, state IDLE, counters 0, delay line cleared; takes effect immediately.
// - States: IDLE -> ACTIVE -> (HBLANK -> ACTIVE)* -> DRAIN -> IDLE.
// - IDLE: start=1 latches bank_sel<=curr_bank, x=y=addr=0, next state ACTIVE.
//   start is ignored in every other state, including the cycle done is high.
// - ACTIVE: mem_rd_en=1, mem_addr=running counter (increment only, no multiplier), x++.
//   At x==IMG_WIDTH-1: x<=0, y++. If y==IMG_HEIGHT-1 -> DRAIN.
//   Else if H_BLANK>0 -> HBLANK. Else stay ACTIVE.
// - HBLANK: mem_rd_en=0 for exactly H_BLANK cycles, mem_addr held, then ACTIVE.
// - DRAIN: mem_rd_en=0 for RD_LATENCY+1 cycles. On the final cycle done<=1 and state<=IDLE.
//   busy falls in the same cycle done rises.
// - Datapath: rd_en delayed RD_LATENCY+1 stages -> pixel_valid. Output regs load only when the
//   delayed strobe is 1: pixel_curr<=bank_sel?rdata_1:rdata_0, pixel_prev<=the other bank.
//   Both hold their last value while pixel_valid=0.
// - Latency: start accepted at cycle 0. mem_rd_en first at cycle 1. First pixel_valid at
//   cycle RD_LATENCY+2. done one cycle after the last pixel_valid.
// - Exactly IMG_WIDTH*IMG_HEIGHT valid beats per frame, strictly raster order, no duplicates.
// - Frame cycles (start accept to done) = 1 + W*H + (H-1)*H_BLANK + RD_LATENCY + 1.
// - Reset mid-frame: stream aborts with no further valid beats. Next start restarts at address 0.
// STRUCTURE
// - optflow_pkg: IMG_WIDTH/IMG_HEIGHT/PIXEL_WIDTH defaults and a streamer_state_e enum.
//   The gradient stage shares these so line-buffer geometry matches the stream.
// - Sub-module: pipe_delay #(WIDTH=1, DEPTH) for the rd_en->pixel_valid strobe delay.
// - Single always_ff for FSM/counters; output registers in a separate always_ff.
// TESTING (IMG_WIDTH=4, IMG_HEIGHT=3; bank0[a]=a, bank1[a]=100+a; 1-cycle-latency memory model)
// 1. Hold rst_n=0, toggle start -> all outputs 0, no mem_rd_en.
// 2. H_BLANK=0, RD_LATENCY=1, curr_bank=0, start -> 12 contiguous beats; curr 0..11,
//    prev 100..111; first valid cycle 3; done cycle 15 for one cycle.
// 3. curr_bank=1 -> curr 100..111, prev 0..11; curr_bank toggled mid-frame has no effect.
// 4. H_BLANK=2 -> 2-cycle gaps after beats 4 and 8 (none after 12); rd_en low in gaps; done at cycle 19.
// 5. start pulsed while busy and in the done cycle -> ignored; next start in IDLE gives a clean frame.
// 6. rst_n low after beat 5, release, start -> no stale beats; new frame begins at address 0.

Source files
------------

// File: rtl/optflow_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : optflow_pkg
//  Description : Shared geometry defaults and streamer state encoding for the
//                optical-flow front end (streamer and gradient stage).
//  Revision    : 1.0 - initial release
// ============================================================================
package optflow_pkg;

  // Default frame geometry; the gradient stage sizes its line buffers from these
  localparam int unsigned OF_PIXEL_WIDTH = 8;
  localparam int unsigned OF_IMG_WIDTH   = 320;
  localparam int unsigned OF_IMG_HEIGHT  = 240;

  // Streamer FSM encoding, explicit 2-bit width
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_DRAIN  = 2'd3
  } streamer_state_e;

  // Counter width for values 0..v-1, never narrower than one bit
  function automatic int unsigned min1_clog2(input int unsigned v);
    int unsigned w;
    w = int'($clog2(v));
    return (w == 0) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_delay.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_delay
//  Description : Fixed-depth register delay line with asynchronous clear.
//                Used to align the read strobe with frame-store read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the input through DEPTH stages; reset empties the whole line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/frame_pair_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_pair_streamer
//  Description : Raster-order reader of a ping-pong frame store. Emits one
//                current/previous pixel pair per beat for the gradient stage,
//                one frame per start pulse, with optional line blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_pair_streamer
  import optflow_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = OF_PIXEL_WIDTH,
  parameter int unsigned IMG_WIDTH   = OF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT  = OF_IMG_HEIGHT,
  parameter int unsigned H_BLANK     = 0,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned ADDR_WIDTH  = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   curr_bank_i,
  output logic                   mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata_0_i,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata_1_i,
  output logic [PIXEL_WIDTH-1:0] pixel_curr_o,
  output logic [PIXEL_WIDTH-1:0] pixel_prev_o,
  output logic                   pixel_valid_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned XW      = min1_clog2(IMG_WIDTH);
  localparam int unsigned YW      = min1_clog2(IMG_HEIGHT);
  // The wait counter serves both the blanking gap and the pipeline drain
  localparam int unsigned CNT_MAX = (H_BLANK > RD_LATENCY + 1) ? H_BLANK : RD_LATENCY + 1;
  localparam int unsigned CW      = min1_clog2(CNT_MAX + 1);

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] HB_LAST = CW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [CW-1:0] DR_LAST = CW'(RD_LATENCY);

  streamer_state_e        state_q, state_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   bank_sel_q, bank_sel_d;
  logic                   done_q, done_d;

  logic                   w_rd_en;
  logic                   w_load;
  logic [PIXEL_WIDTH-1:0] pixel_curr_q;
  logic [PIXEL_WIDTH-1:0] pixel_prev_q;
  logic                   pixel_valid_q;

  // Next-state logic: raster walk with a running address (no y*W multiply)
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    bank_sel_d = bank_sel_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse is dropped, not queued
        if (start_i && !done_q) begin
          bank_sel_d = curr_bank_i;
          x_d        = '0;
          y_d        = '0;
          addr_d     = '0;
          cnt_d      = '0;
          state_d    = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (x_q == X_LAST) begin
          x_d   = '0;
          cnt_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            state_d = ST_DRAIN;
          end else begin
            y_d = y_q + YW'(1);
            if (H_BLANK > 0) begin
              state_d = ST_HBLANK;
            end
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      ST_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          cnt_d   = '0;
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        // Wait until the last read has reached the output registers
        if (cnt_q == DR_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      bank_sel_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      bank_sel_q <= bank_sel_d;
      done_q     <= done_d;
    end
  end

  assign w_rd_en = (state_q == ST_ACTIVE);

  // Strobe arrives together with read data, then one more stage to the outputs
  pipe_delay #(
    .WIDTH (1),
    .DEPTH (RD_LATENCY)
  ) u_rd_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (w_rd_en),
    .q_o   (w_load)
  );

  // Output pixel registers; hold last pair while no strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid_q <= 1'b0;
      pixel_curr_q  <= '0;
      pixel_prev_q  <= '0;
    end else begin
      pixel_valid_q <= w_load;
      if (w_load) begin
        pixel_curr_q <= bank_sel_q ? mem_rdata_1_i : mem_rdata_0_i;
        pixel_prev_q <= bank_sel_q ? mem_rdata_0_i : mem_rdata_1_i;
      end
    end
  end

  assign mem_rd_en_o   = w_rd_en;
  assign mem_addr_o    = addr_q;
  assign pixel_curr_o  = pixel_curr_q;
  assign pixel_prev_o  = pixel_prev_q;
  assign pixel_valid_o = pixel_valid_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_pair_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_pair_streamer
//  Description : Self-checking bench for frame_pair_streamer. Two instances
//                (no blanking / 2-cycle blanking) on a 4x3 frame with a
//                1-cycle-latency two-bank memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_pair_streamer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 8;
  localparam int AW = $clog2(W*H);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: H_BLANK=0, instance B: H_BLANK=2
  logic          start_a = 1'b0, start_b = 1'b0, bank_a = 1'b0, bank_b = 1'b0;
  logic          rd_a, rd_b, val_a, val_b, busy_a, busy_b, done_a, done_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [PW-1:0] r0_a = '0, r1_a = '0, r0_b = '0, r1_b = '0;
  logic [PW-1:0] cur_a, prv_a, cur_b, prv_b;

  frame_pair_streamer #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                        .H_BLANK(0), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .curr_bank_i(bank_a),
    .mem_rd_en_o(rd_a), .mem_addr_o(addr_a), .mem_rdata_0_i(r0_a), .mem_rdata_1_i(r1_a),
    .pixel_curr_o(cur_a), .pixel_prev_o(prv_a), .pixel_valid_o(val_a),
    .busy_o(busy_a), .done_o(done_a));

  frame_pair_streamer #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                        .H_BLANK(2), .RD_LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .curr_bank_i(bank_b),
    .mem_rd_en_o(rd_b), .mem_addr_o(addr_b), .mem_rdata_0_i(r0_b), .mem_rdata_1_i(r1_b),
    .pixel_curr_o(cur_b), .pixel_prev_o(prv_b), .pixel_valid_o(val_b),
    .busy_o(busy_b), .done_o(done_b));

  // Frame store model: bank0[a]=a, bank1[a]=100+a, data one cycle after rd_en
  always @(posedge clk) begin
    if (rd_a) begin r0_a <= PW'(addr_a); r1_a <= PW'(100 + int'(addr_a)); end
    if (rd_b) begin r0_b <= PW'(addr_b); r1_b <= PW'(100 + int'(addr_b)); end
  end

  // Observed instance selection
  logic          sel = 1'b0;
  logic          m_rd, m_val, m_busy, m_done;
  logic [AW-1:0] m_addr;
  logic [PW-1:0] m_cur, m_prv;
  always_comb begin
    m_rd   = sel ? rd_b   : rd_a;
    m_val  = sel ? val_b  : val_a;
    m_busy = sel ? busy_b : busy_a;
    m_done = sel ? done_b : done_a;
    m_addr = sel ? addr_b : addr_a;
    m_cur  = sel ? cur_b  : cur_a;
    m_prv  = sel ? prv_b  : prv_a;
  end

  // Scoreboards: expected reads and expected pixel pairs with relative cycle
  typedef struct { int rel; logic [AW-1:0] addr; } rd_exp_t;
  typedef struct { int rel; logic [PW-1:0] cur; logic [PW-1:0] prv; } px_exp_t;
  rd_exp_t rd_q[$];
  px_exp_t px_q[$];

  int checks     = 0;
  int failures   = 0;
  int c0         = 0;
  int beats_seen = 0;
  int first_rel  = -1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every read strobe and every valid beat must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_rd) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected: rd_en=1 addr=%0d with no read expected", m_addr);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          if (e.rel != cyc - c0 || e.addr != m_addr) begin
            failures++;
            $display("FAIL rd_stream: got addr=%0d cycle=%0d expected addr=%0d cycle=%0d",
                     m_addr, cyc - c0, e.addr, e.rel);
          end
        end
      end
      if (m_val) begin
        checks++;
        if (px_q.size() == 0) begin
          failures++;
          $display("FAIL px_unexpected: valid beat curr=%0d prev=%0d with none expected", m_cur, m_prv);
        end else begin
          px_exp_t p;
          p = px_q.pop_front();
          beats_seen++;
          if (first_rel < 0) first_rel = cyc - c0;
          if (p.rel != cyc - c0 || p.cur != m_cur || p.prv != m_prv) begin
            failures++;
            $display("FAIL px_stream: got curr=%0d prev=%0d cycle=%0d expected curr=%0d prev=%0d cycle=%0d",
                     m_cur, m_prv, cyc - c0, p.cur, p.prv, p.rel);
          end
        end
      end
    end
  end

  task automatic drive_start(input logic s);
    if (sel) start_b = s; else start_a = s;
  endtask

  task automatic drive_bank(input logic b);
    if (sel) bank_b = b; else bank_a = b;
  endtask

  // Expected stream for one frame: read at 1+b+gaps, pixel two cycles later
  task automatic push_frame(input logic bank, input int hb);
    for (int b = 0; b < W*H; b++) begin
      rd_exp_t r;
      px_exp_t p;
      r.rel  = 1 + b + (b / W) * hb;
      r.addr = AW'(b);
      p.rel  = r.rel + 2;
      p.cur  = bank ? PW'(100 + b) : PW'(b);
      p.prv  = bank ? PW'(b) : PW'(100 + b);
      rd_q.push_back(r);
      px_q.push_back(p);
    end
  endtask

  typedef struct {
    logic sel;        // 0: no blanking, 1: 2-cycle blanking
    logic bank;       // curr_bank at start
    logic toggle;     // flip curr_bank mid-frame
    logic poke;       // pulse start mid-frame and in the done cycle
    int   exp_first;  // expected first pixel_valid cycle
    int   exp_done;   // expected done cycle
  } frame_vec_t;

  frame_vec_t vecs[4];

  task automatic run_frame(input frame_vec_t v);
    logic seen_done;
    int   rel;
    seen_done  = 1'b0;
    sel        = v.sel;
    first_rel  = -1;
    push_frame(v.bank, v.sel ? 2 : 0);
    @(negedge clk);
    drive_bank(v.bank);
    drive_start(1'b1);
    c0 = cyc;
    for (int k = 0; k < 60 && !seen_done; k++) begin
      @(negedge clk);
      rel = cyc - c0;
      drive_start(1'b0);
      if (rel == 1) check("busy_after_start", int'(m_busy), 1);
      if (v.toggle && rel == 5) drive_bank(~v.bank);
      if (v.poke && rel == 7) drive_start(1'b1);
      if (m_done) begin
        seen_done = 1'b1;
        check("done_cycle", rel, v.exp_done);
        check("busy_low_at_done", int'(m_busy), 0);
        if (v.poke) drive_start(1'b1);
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    @(negedge clk);
    drive_start(1'b0);
    check("done_one_cycle", int'(m_done), 0);
    check("idle_after_done", int'(m_busy), 0);
    check("first_valid_cycle", first_rel, v.exp_first);
    check("rd_queue_drained", rd_q.size(), 0);
    check("px_queue_drained", px_q.size(), 0);
    drive_bank(1'b0);
  endtask

  function automatic int all_outputs();
    return int'({rd_a, rd_b, val_a, val_b, busy_a, busy_b, done_a, done_b})
         + int'(addr_a) + int'(addr_b) + int'(cur_a) + int'(prv_a) + int'(cur_b) + int'(prv_b);
  endfunction

  initial begin
    vecs[0] = '{sel: 1'b0, bank: 1'b0, toggle: 1'b0, poke: 1'b0, exp_first: 3, exp_done: 15};
    vecs[1] = '{sel: 1'b0, bank: 1'b1, toggle: 1'b1, poke: 1'b1, exp_first: 3, exp_done: 15};
    vecs[2] = '{sel: 1'b1, bank: 1'b0, toggle: 1'b0, poke: 1'b0, exp_first: 3, exp_done: 19};
    vecs[3] = '{sel: 1'b1, bank: 1'b1, toggle: 1'b1, poke: 1'b1, exp_first: 3, exp_done: 19};

    // Held in reset with start toggling: everything stays at zero
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_a = ~start_a;
      start_b = ~start_b;
      check("reset_outputs_zero", all_outputs(), 0);
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n   = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i]);
      repeat (2) @(negedge clk);
    end

    // Reset in the middle of a frame, then a fresh frame from address 0
    sel        = 1'b0;
    beats_seen = 0;
    first_rel  = -1;
    push_frame(1'b0, 0);
    @(negedge clk);
    start_a = 1'b1;
    c0      = cyc;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 40 && beats_seen < 5; k++) @(negedge clk);
    check("midframe_beats_reached", int'(beats_seen >= 5), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", all_outputs(), 0);
    rd_q.delete();
    px_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
